imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that fills the MIPS instruction memory from a byte stream and holds the CPU in reset until a complete, checksum-verified image has been written. It is the writer for the instruction memory the CPU core reads from: it sits between an external byte source (UART RX, testbench, debug bridge) and the instruction-memory write port, and drives the core's reset.

## Interface
Parameters:
- `MAX_WORDS`, 256: largest accepted image, in 32-bit words.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first written word; word-aligned.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  byte-source valid.
- `in_data`  in  8  byte value, qualified by `in_valid`.
- `in_ready`  out  1  loader accepts a byte; transfer when `in_valid & in_ready`.
- `load_req`  in  1  one-cycle pulse; restarts loading from `S_DONE` or `S_ERR`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address, `BASE_ADDR + 4*index`.
- `imem_wdata`  out  32  instruction word.
- `cpu_reset`  out  1  drives the core's `reset`; high while no valid image is present.
- `done`  out  1  image loaded and verified.
- `error`  out  1  load failed (oversize or checksum mismatch).

## Operation
- Stream format: 4-byte word count N (MSB first), then N words of 4 bytes each (MSB first, big-endian), then 1 checksum byte equal to the XOR of all payload bytes. Header bytes are excluded from the checksum.
- States:
  - `S_IDLE`: the reset state. Moves to `S_LEN` unconditionally on the next cycle.
  - `S_LEN`: collects 4 count bytes.
    - N > `MAX_WORDS` → `S_ERR`.
    - N == 0 → `S_CHK`.
    - Otherwise → `S_DATA`.
  - `S_DATA`: shifts bytes into a 32-bit assembly register. On each 4th byte it issues a write and increments the word index. After word N it moves to `S_CHK`.
  - `S_CHK`: accepts 1 byte.
    - Byte equals the running XOR → `S_DONE`.
    - Otherwise → `S_ERR`.
  - `S_DONE`: `done=1`, `cpu_reset=0`.
  - `S_ERR`: `error=1`, `cpu_reset=1`.
  - `load_req` in either terminal state → `S_LEN`. Index, checksum and byte counter are cleared, and `done`/`error` drop.
- `load_req` is ignored in all other states.
- `in_ready` is 1 only in `S_LEN`, `S_DATA` and `S_CHK`. Bytes are never dropped and never accepted in other states.
- Idle cycles (`in_valid=0`) between bytes are allowed anywhere and do not change state.
- Words already written before an error stay in memory; the loader performs no rollback.

## Timing
- Reset values:
  - `in_ready=0`, `imem_we=0`, `imem_addr=BASE_ADDR`, `imem_wdata=0`.
  - `cpu_reset=1`, `done=0`, `error=0`.
- All outputs are registered except `in_ready`, which is decoded from the state register.
- Write latency: `imem_we` is high for exactly one cycle, the cycle after the 4th byte of a word is accepted, with `imem_addr`/`imem_wdata` valid in that cycle. With back-to-back input there is at most one write every 4 cycles.
- `cpu_reset` falls and `done` rises in the same cycle, 1 cycle after the checksum byte is accepted.
- `error` rises 1 cycle after the offending count byte or checksum byte is accepted.
- `load_req`: `cpu_reset` rises and `done`/`error` fall on the next cycle. `in_ready` is 1 from that cycle.
- Word index is `$clog2(MAX_WORDS+1)` bits. The N comparison uses the full 32-bit count, so there is no wrap.
- Asynchronous `reset` mid-load returns to `S_IDLE` immediately. `cpu_reset` is forced to 1 and any pending write strobe is cancelled.

## Structure
- Shared package `loader_pkg`:
  - state enum (`S_IDLE`, `S_LEN`, `S_DATA`, `S_CHK`, `S_DONE`, `S_ERR`);
  - header length constant (4);
  - bytes-per-word constant (4).
- Sub-module `byte_packer`: shifts 4 bytes MSB-first into a 32-bit word and emits a one-cycle `word_valid`. It is reused for both the count and the data words.
- The FSM, index counter, XOR accumulator and address register live in `imem_loader`.

## Test plan
- 2-word load: stream `00 00 00 02 20 08 00 05 00 00 00 00 2D` → two writes, `imem_addr=0x0` with `imem_wdata=0x20080005`, then `0x4` with `0x00000000`. `done=1` and `cpu_reset=0` one cycle after `2D`.
- Zero-length load: stream `00 00 00 00 00` → no `imem_we` pulses, `done=1`.
- Bad checksum: the 2-word stream with final byte `2C` → both writes occur, `error=1`, `cpu_reset` stays 1, `in_ready=0`.
- Oversize load (`MAX_WORDS=256`): count `00 00 01 01` → `error=1` after the 4th header byte, no writes.
- Backpressure and gaps: the 2-word stream with `in_valid` randomly low 50% of cycles, plus `load_req` pulsed in `S_DATA` → identical writes and `done`; `load_req` is ignored.
- Reload and mid-load reset:
  - After `done`, pulse `load_req` and send a 1-word image → `cpu_reset` returns to 1, then falls after the new checksum.
  - Assert `reset` after 6 bytes → all outputs return to their reset values; a fresh stream then loads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader: loader state encoding, header length and word size.
// Revision    : 1.0  initial release
// ============================================================================
package loader_pkg;

    // Loader states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Length of the word-count header, in bytes.
    localparam int unsigned c_hdr_bytes      = 4;
    // Bytes per instruction word.
    localparam int unsigned c_bytes_per_word = 4;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Shifts bytes MSB-first into a 32-bit word. o_word_valid is
//               asserted combinationally in the cycle the final byte of a
//               word is presented, with o_word holding the complete word, so
//               the consumer can act on the word at that same clock edge.
//               Used for both the count header and the payload words.
// Ports       : clk, reset    - clock, asynchronous active-high reset
//               i_clear       - synchronous restart of byte position
//               i_byte_en     - a byte is being accepted this cycle
//               i_byte        - accepted byte value
//               o_word_valid  - this byte completes a word
//               o_word        - assembled word (valid with o_word_valid)
// Revision    : 1.0  initial release
// ============================================================================
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam logic [1:0] c_last = 2'(c_bytes_per_word - 1);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_clear) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_byte_en) begin
            // Counter wraps from the last position back to 0 naturally.
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
        end
    end

    assign o_word_valid = i_byte_en && (r_cnt == c_last);
    assign o_word       = {r_shift, i_byte};

endmodule : byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time loader. Receives a byte stream
//               [N: 4 bytes MSB first][N words, big-endian][XOR checksum],
//               writes the words into instruction memory starting at
//               BASE_ADDR and holds the CPU in reset until a complete,
//               checksum-verified image is present.
// Ports       : clk, reset          - clock, asynchronous active-high reset
//               in_valid/in_data    - byte source
//               in_ready            - loader accepts a byte (state decode)
//               load_req            - restart from a terminal state
//               imem_we/addr/wdata  - instruction-memory write port
//               cpu_reset           - core reset, high without valid image
//               done / error        - load verified / load failed
// Revision    : 1.0  initial release
// ============================================================================
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        load_req,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam int unsigned c_idx_w = $clog2(MAX_WORDS + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_idx_w-1:0]   r_index;
    logic [c_idx_w-1:0]   r_count;
    logic [c_idx_w-1:0]   w_index_inc;
    logic [7:0]           r_xor;
    logic                 w_accept;
    logic                 w_restart;
    logic                 w_pack_en;
    logic                 w_word_valid;
    logic [31:0]          w_word;

    assign in_ready    = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
    assign w_accept    = in_valid && in_ready;
    assign w_restart   = load_req && ((r_state == S_DONE) || (r_state == S_ERR));
    assign w_pack_en   = w_accept && ((r_state == S_LEN) || (r_state == S_DATA));
    assign w_index_inc = r_index + 1'b1;

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_restart),
        .i_byte_en    (w_pack_en),
        .i_byte       (in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: w_state_nxt = S_LEN;
            S_LEN: begin
                if (w_word_valid) begin
                    // Full 32-bit compare: huge counts must not alias into range.
                    if (w_word > 32'(MAX_WORDS)) begin
                        w_state_nxt = S_ERR;
                    end else if (w_word == 32'd0) begin
                        w_state_nxt = S_CHK;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_word_valid && (w_index_inc == r_count)) begin
                    w_state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    w_state_nxt = (in_data == r_xor) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (load_req) begin
                    w_state_nxt = S_LEN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs. Status outputs are derived from the
    // next state so they change in the same cycle the state does.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index    <= '0;
            r_count    <= '0;
            r_xor      <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we   <= 1'b0;
            done      <= (w_state_nxt == S_DONE);
            error     <= (w_state_nxt == S_ERR);
            cpu_reset <= (w_state_nxt != S_DONE);

            if (w_restart) begin
                r_index <= '0;
                r_count <= '0;
                r_xor   <= 8'd0;
            end else begin
                // Only the low bits are kept; out-of-range counts go to S_ERR.
                if ((r_state == S_LEN) && w_word_valid) begin
                    r_count <= w_word[c_idx_w-1:0];
                end
                if ((r_state == S_DATA) && w_accept) begin
                    r_xor <= r_xor ^ in_data;
                end
                if ((r_state == S_DATA) && w_word_valid) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= BASE_ADDR + (32'(r_index) << 2);
                    imem_wdata <= w_word;
                    r_index    <= w_index_inc;
                end
            end
        end
    end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Images are described as
//               word lists; the expected byte stream, write sequence and final
//               status are computed from the stream format rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    localparam int unsigned MAX_W = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        load_req = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int we_pulses = 0;
    logic [31:0] img[$];

    imem_loader #(.MAX_WORDS(MAX_W), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Every cycle with the strobe high is one write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) we_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string name);
        check({name, " in_ready"},   32'(in_ready),  32'd0);
        check({name, " imem_we"},    32'(imem_we),   32'd0);
        check({name, " imem_addr"},  imem_addr,      BASE);
        check({name, " imem_wdata"}, imem_wdata,     32'd0);
        check({name, " cpu_reset"},  32'(cpu_reset), 32'd1);
        check({name, " done"},       32'(done),      32'd0);
        check({name, " error"},      32'(error),     32'd0);
    endtask

    task automatic do_load_req(input string name);
        @(negedge clk);
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        check({name, " cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({name, " done"},      32'(done),      32'd0);
        check({name, " error"},     32'(error),     32'd0);
        check({name, " in_ready"},  32'(in_ready),  32'd1);
    endtask

    // Asserted right where the caller stands (possibly mid-write-strobe).
    task automatic reset_pulse(input string name);
        reset = 1'b1;
        #1;
        check_reset_values(name);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Builds the stream for the words in img with header value n_hdr, sends
    // it (optionally with gaps, a load_req pulse at byte req_at, or only the
    // first 'limit' bytes) and checks writes and final status.
    task automatic run_image(input string name, input logic [31:0] n_hdr, input bit bad_ck,
                             input int gap_pct, input int req_at, input int limit);
        logic [7:0]  bytes[$];
        bit          word_end[$];
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [7:0]  ck;
        bit          oversize;
        bit          exp_done;
        int          n_send;
        int          base_pulses;
        int          wi;
        ck = 8'd0;
        wi = 0;
        oversize = (n_hdr > MAX_W);
        exp_done = !oversize && !bad_ck;
        for (int s = 3; s >= 0; s--) begin
            bytes.push_back(n_hdr[8*s +: 8]);
            word_end.push_back(1'b0);
        end
        if (!oversize) begin
            foreach (img[i]) begin
                for (int s = 3; s >= 0; s--) begin
                    bytes.push_back(img[i][8*s +: 8]);
                    ck ^= img[i][8*s +: 8];
                    word_end.push_back(s == 0);
                end
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back(img[i]);
            end
            bytes.push_back(bad_ck ? (ck ^ 8'h01) : ck);
            word_end.push_back(1'b0);
        end

        n_send = (limit < 0) ? bytes.size() : limit;
        base_pulses = we_pulses;
        for (int k = 0; k < n_send; k++) begin
            int waited;
            bit accepted;
            waited = 0;
            accepted = 1'b0;
            while (!accepted) begin
                @(negedge clk);
                load_req = (k == req_at) && (waited == 0);
                in_valid = ($urandom_range(99) >= gap_pct);
                in_data  = in_valid ? bytes[k] : 8'($urandom);
                if (in_valid && in_ready) begin
                    @(posedge clk);
                    accepted = 1'b1;
                end else begin
                    waited++;
                    if (waited > 200) begin
                        check({name, " byte accepted in time"}, 32'd0, 32'd1);
                        in_valid = 1'b0;
                        load_req = 1'b0;
                        return;
                    end
                end
            end
            #1;
            in_valid = 1'b0;
            load_req = 1'b0;
            check({name, " we"}, 32'(imem_we), 32'(word_end[k]));
            if (word_end[k]) begin
                check({name, " addr"},  imem_addr,  exp_addr[wi]);
                check({name, " wdata"}, imem_wdata, exp_data[wi]);
                wi++;
            end
            if (k == bytes.size() - 1) begin
                check({name, " done"},      32'(done),      32'(exp_done));
                check({name, " error"},     32'(error),     32'(!exp_done));
                check({name, " cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
                check({name, " in_ready"},  32'(in_ready),  32'd0);
            end else begin
                check({name, " cpu_reset held"}, 32'(cpu_reset), 32'd1);
            end
        end
        if (limit < 0) begin
            repeat (3) @(negedge clk);
            check({name, " write count"}, 32'(we_pulses - base_pulses), 32'(exp_addr.size()));
            check({name, " status stable"}, 32'(done), 32'(exp_done));
        end
    endtask

    initial begin
        // Power-on reset
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;

        // Directed 2-word image (checksum 2D)
        img = '{32'h2008_0005, 32'h0000_0000};
        run_image("two_word", 32'd2, 1'b0, 0, -1, -1);

        // Reload with a 1-word image
        do_load_req("reload");
        img = '{32'hDEAD_BEEF};
        run_image("one_word", 32'd1, 1'b0, 0, -1, -1);

        // Zero-length image
        do_load_req("req_zero");
        img.delete();
        run_image("zero_len", 32'd0, 1'b0, 0, -1, -1);

        // Bad checksum (2C instead of 2D)
        do_load_req("req_badck");
        img = '{32'h2008_0005, 32'h0000_0000};
        run_image("bad_ck", 32'd2, 1'b1, 0, -1, -1);

        // Oversize counts, including one whose low bits look small
        do_load_req("req_from_err");
        img.delete();
        run_image("oversize", 32'd257, 1'b0, 0, -1, -1);
        do_load_req("req_wrap");
        run_image("wrap_n", 32'h0001_0001, 1'b0, 0, -1, -1);

        // Gaps plus an ignored load_req while in the data phase
        do_load_req("req_gaps");
        img = '{32'h2008_0005, 32'h0000_0000};
        run_image("gaps", 32'd2, 1'b0, 50, 6, -1);

        // Random images
        for (int r = 0; r < 4; r++) begin
            int n;
            do_load_req("req_rand");
            img.delete();
            n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) img.push_back($urandom);
            run_image("rand", 32'(n), ($urandom_range(3) == 0), 30, -1, -1);
        end

        // Largest accepted image
        do_load_req("req_max");
        img.delete();
        for (int i = 0; i < int'(MAX_W); i++) img.push_back($urandom);
        run_image("max_words", 32'(MAX_W), 1'b0, 0, -1, -1);

        // Reset after 6 bytes, then a fresh load
        do_load_req("req_part6");
        img = '{32'h2008_0005, 32'h0000_0000};
        run_image("part6", 32'd2, 1'b0, 0, -1, 6);
        reset_pulse("rst6");
        img = '{32'h1234_5678, 32'h9ABC_DEF0};
        run_image("after_rst6", 32'd2, 1'b0, 0, -1, -1);

        // Reset while a write strobe is high
        do_load_req("req_part8");
        img = '{32'hCAFE_F00D, 32'h0BAD_D00D};
        run_image("part8", 32'd2, 1'b0, 0, -1, 8);
        reset_pulse("rst8");
        img = '{32'h0000_0001};
        run_image("after_rst8", 32'd1, 1'b0, 20, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
